result_drain_ctrl: RTL and testbench
====================================

Name: result_drain_ctrl

Overview:
- Sequences the per-row result shift chain of the sparse CNN PE array after a compute pass finishes.
- Drives the chain's ResultCapture select and a stage update enable.
- First loads every stage's local result in parallel, then shifts the words out of the chain tail one per accepted transfer.
- Sits between the PE-array compute controller (start) and the output buffer writer (valid/ready).

Parameters:
- CHAIN_LEN, 4, number of stages in the result chain; one output word per stage per drain.
- IDX_W, 3, width of out_idx; must satisfy 2**IDX_W > CHAIN_LEN.

Ports:
- Clk  input  1  clock, all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  single-cycle pulse: local results valid, begin drain.
- out_ready  input  1  downstream writer accepts the current tail word.
- ResultCapture  output  1  chain select: 0 = load local results, 1 = shift from upstream neighbour.
- shift_en  output  1  chain stage register update enable.
- out_valid  output  1  chain tail holds a word to transfer.
- out_last  output  1  current word is the final word of this drain.
- out_idx  output  IDX_W  position of the current word, 0 = first word out.
- busy  output  1  high in every state except IDLE.
- done  output  1  single-cycle pulse after the last transfer.

Behaviour:
- Reset (rst=1 at a rising edge):
  - state=IDLE, word counter=0.
  - All outputs: busy=0, done=0, out_valid=0, out_last=0, out_idx=0, shift_en=0, ResultCapture=1.
  - Reset mid-drain abandons the drain immediately. No done pulse. Chain contents are not cleared by this block.
- States: IDLE, LOAD, SHIFT, DONE.
- IDLE:
  - ResultCapture=1, shift_en=0.
  - start=1 -> LOAD.
- LOAD (exactly 1 cycle):
  - ResultCapture=0, shift_en=1, so every stage captures its local result at the end of this cycle.
  - Next state SHIFT; counter=0.
- SHIFT:
  - ResultCapture=1, out_valid=1, out_idx=counter, out_last=(counter==CHAIN_LEN-1).
  - shift_en = out_ready, combinational, same cycle.
  - A transfer occurs on a cycle with out_valid & out_ready. On each transfer the counter increments. If out_last is set, next state is DONE instead.
  - out_ready=0 holds the chain (shift_en=0) and holds out_idx. out_valid stays high and the word stays stable; no word is lost or duplicated.
- DONE (1 cycle):
  - done=1, busy=1, out_valid=0, shift_en=0.
  - Next state IDLE.
- Latency: start at cycle T -> LOAD at T+1 -> first out_valid at T+2. With out_ready held high, the last transfer is at T+CHAIN_LEN+1, done at T+CHAIN_LEN+2, and start is accepted again at T+CHAIN_LEN+3.
- Output timing: ResultCapture, busy, done, out_valid, out_last and out_idx decode from registered state and counter only. shift_en is the only output combinationally dependent on an input (out_ready).
- start while not in IDLE: behaviour set by the optional feature below.
- Counter arithmetic is unsigned IDX_W bits. It never exceeds CHAIN_LEN-1 in SHIFT and never wraps.
- CHAIN_LEN=1: a single SHIFT transfer with out_last=1 on idx 0.

Optional Feature:
- Macro: RESULT_DRAIN_QUEUE_EN.
- Defined:
  - A one-deep pending flag sets on start while busy=1, and clears on reset.
  - On leaving DONE with the flag set, go to LOAD instead of IDLE and clear the flag. This gives back-to-back drains with no IDLE cycle.
  - A start while the flag is already set is dropped.
  - A start arriving in the DONE cycle itself sets the flag.
- Undefined: start while busy=1 is ignored; no extra state.

Test Plan:
- CHAIN_LEN=4, rst high 2 cycles then low -> all outputs at reset values. Outputs stay there while start=0.
- start at T, out_ready=1 -> LOAD at T+1 (ResultCapture=0, shift_en=1). out_valid T+2..T+5 with out_idx 0,1,2,3. out_last only at idx 3. done=1 only at T+6. busy falls at T+7.
- Same drain with out_ready low at idx 1 for 3 cycles -> shift_en=0 and out_idx=1 held for those 3 cycles. Exactly 4 transfers total, done 3 cycles later than above.
- start pulsed again during SHIFT idx 2:
  - Macro undefined -> ignored, IDLE after done.
  - Macro defined -> LOAD on the cycle after DONE, second full 4-word drain.
- rst asserted while in SHIFT at idx 2 -> next cycle state IDLE, out_valid=0, shift_en=0, no done pulse. A fresh start then restarts at idx 0.
- CHAIN_LEN=1 build, start with out_ready=1 -> one out_valid cycle with out_idx=0 and out_last=1, then done.

Source files
------------

// File: rtl/result_drain_ctrl.sv
// Drain sequencer for the per-row PE result shift chain: one parallel load, then one word per accepted transfer.
// Optional back-to-back queueing of a start that arrives while busy: define RESULT_DRAIN_QUEUE_EN.
module result_drain_ctrl #(
    parameter int CHAIN_LEN = 4,
    parameter int IDX_W     = 3
) (
    input  logic             Clk,
    input  logic             rst,
    input  logic             start,
    input  logic             out_ready,
    output logic             ResultCapture,
    output logic             shift_en,
    output logic             out_valid,
    output logic             out_last,
    output logic [IDX_W-1:0] out_idx,
    output logic             busy,
    output logic             done
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_LOAD  = 2'd1,
        S_SHIFT = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(CHAIN_LEN - 1);

    state_t           state, state_nxt;
    logic [IDX_W-1:0] cnt, cnt_nxt;
    logic             cnt_last;
    logic             xfer;
    logic             launch_from_done;

    assign cnt_last = (cnt == LAST_IDX);
    assign xfer     = (state == S_SHIFT) && out_ready;

`ifdef RESULT_DRAIN_QUEUE_EN
    logic pending, pending_nxt;

    // A start landing in the DONE cycle counts as already pending, so the
    // next drain launches straight from DONE instead of stranding in IDLE.
    assign launch_from_done = pending || start;

    always_comb begin
        pending_nxt = pending;
        if (state == S_DONE)
            pending_nxt = 1'b0;
        else if (busy && start)
            pending_nxt = 1'b1;
    end

    always_ff @(posedge Clk) begin
        if (rst)
            pending <= 1'b0;
        else
            pending <= pending_nxt;
    end
`else
    assign launch_from_done = 1'b0;
`endif

    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples the pre-edge value of every other register.
    always_ff @(posedge Clk) begin
        if (rst) begin
            state <= S_IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    // NOTE: every variable gets its default before the case, so no path
    // through this block can leave one unassigned and infer a latch.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        unique case (state)
            S_IDLE: begin
                if (start)
                    state_nxt = S_LOAD;
            end
            S_LOAD: begin
                state_nxt = S_SHIFT;
                cnt_nxt   = '0;
            end
            S_SHIFT: begin
                if (xfer) begin
                    if (cnt_last)
                        state_nxt = S_DONE;
                    else
                        cnt_nxt = cnt + IDX_W'(1);
                end
            end
            S_DONE: begin
                state_nxt = launch_from_done ? S_LOAD : S_IDLE;
                cnt_nxt   = '0;
            end
            default: begin
                state_nxt = S_IDLE;
                cnt_nxt   = '0;
            end
        endcase
    end

    // Everything except shift_en decodes from registered state/counter only.
    always_comb begin
        ResultCapture = 1'b1;
        shift_en      = 1'b0;
        out_valid     = 1'b0;
        out_last      = 1'b0;
        out_idx       = '0;
        busy          = (state != S_IDLE);
        done          = 1'b0;
        unique case (state)
            S_IDLE: ;
            S_LOAD: begin
                ResultCapture = 1'b0;
                shift_en      = 1'b1;
            end
            S_SHIFT: begin
                out_valid = 1'b1;
                out_idx   = cnt;
                out_last  = cnt_last;
                shift_en  = out_ready;
            end
            S_DONE: begin
                done = 1'b1;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_result_drain_ctrl.sv
// Directed bench for result_drain_ctrl: CHAIN_LEN=4 drains (stall, start-while-busy, reset mid-drain) and a CHAIN_LEN=1 drain.
// Expectations for start-while-busy follow RESULT_DRAIN_QUEUE_EN when the bench is built with it.
module tb_result_drain_ctrl;

    logic       Clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic       start1 = 1'b0;
    logic       out_ready = 1'b0;

    logic       rc0, se0, ov0, ol0, bz0, dn0;
    logic [2:0] idx0;
    logic       rc1, se1, ov1, ol1, bz1, dn1;
    logic [0:0] idx1;

    int checks = 0;
    int errors = 0;
    int xfers  = 0;
    int xfer_base;

    always #5 Clk = ~Clk;

    result_drain_ctrl #(.CHAIN_LEN(4), .IDX_W(3)) dut (
        .Clk(Clk), .rst(rst), .start(start), .out_ready(out_ready),
        .ResultCapture(rc0), .shift_en(se0), .out_valid(ov0), .out_last(ol0),
        .out_idx(idx0), .busy(bz0), .done(dn0)
    );

    result_drain_ctrl #(.CHAIN_LEN(1), .IDX_W(1)) dut1 (
        .Clk(Clk), .rst(rst), .start(start1), .out_ready(out_ready),
        .ResultCapture(rc1), .shift_en(se1), .out_valid(ov1), .out_last(ol1),
        .out_idx(idx1), .busy(bz1), .done(dn1)
    );

    always @(posedge Clk)
        if (!rst && ov0 && out_ready)
            xfers <= xfers + 1;

    logic [8:0] obs0, obs1;
    assign obs0 = {rc0, se0, ov0, ol0, idx0, bz0, dn0};
    assign obs1 = {rc1, se1, ov1, ol1, 2'b00, idx1, bz1, dn1};

    function automatic logic [8:0] ev(input logic rc, input logic se, input logic ov,
                                      input logic ol, input logic [2:0] idx,
                                      input logic bz, input logic dn);
        return {rc, se, ov, ol, idx, bz, dn};
    endfunction

    localparam logic [8:0] V_IDLE = {1'b1, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0};
    localparam logic [8:0] V_LOAD = {1'b0, 1'b1, 1'b0, 1'b0, 3'd0, 1'b1, 1'b0};
    localparam logic [8:0] V_DONE = {1'b1, 1'b0, 1'b0, 1'b0, 3'd0, 1'b1, 1'b1};

    function automatic logic [8:0] v_shift(input logic [2:0] idx, input logic se, input logic last);
        return ev(1'b1, se, 1'b1, last, idx, 1'b1, 1'b0);
    endfunction

    task automatic check(input string tag, input logic [8:0] got, input logic [8:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %b expected %b", tag, got, exp);
        end
    endtask

    task automatic check_int(input string tag, input int got, input int exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
        end
    endtask

    // Advance to the next cycle, apply inputs, let combinational outputs settle.
    task automatic cyc(input logic s, input logic r);
        @(negedge Clk);
        start     = s;
        out_ready = r;
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        // Reset and idle hold
        rst = 1'b1;
        cyc(0, 0);
        cyc(0, 0);
        rst = 1'b0;
        cyc(0, 0);
        check("reset_outputs", obs0, V_IDLE);
        check("reset_outputs_len1", obs1, V_IDLE);
        cyc(0, 1);
        check("idle_hold_a", obs0, V_IDLE);
        cyc(0, 1);
        check("idle_hold_b", obs0, V_IDLE);

        // Drain 1: out_ready held high
        xfer_base = xfers;
        cyc(1, 1);
        check("d1_T_idle", obs0, V_IDLE);
        cyc(0, 1);
        check("d1_load", obs0, V_LOAD);
        cyc(0, 1);
        check("d1_idx0", obs0, v_shift(3'd0, 1'b1, 1'b0));
        cyc(0, 1);
        check("d1_idx1", obs0, v_shift(3'd1, 1'b1, 1'b0));
        cyc(0, 1);
        check("d1_idx2", obs0, v_shift(3'd2, 1'b1, 1'b0));
        cyc(0, 1);
        check("d1_idx3_last", obs0, v_shift(3'd3, 1'b1, 1'b1));
        cyc(0, 1);
        check("d1_done", obs0, V_DONE);
        cyc(0, 1);
        check("d1_idle_after", obs0, V_IDLE);
        check_int("d1_xfers", xfers - xfer_base, 4);

        // Drain 2: stall 3 cycles at idx 1
        xfer_base = xfers;
        cyc(1, 1);
        cyc(0, 1);
        check("d2_load", obs0, V_LOAD);
        cyc(0, 1);
        check("d2_idx0", obs0, v_shift(3'd0, 1'b1, 1'b0));
        cyc(0, 0);
        check("d2_stall1", obs0, v_shift(3'd1, 1'b0, 1'b0));
        cyc(0, 0);
        check("d2_stall2", obs0, v_shift(3'd1, 1'b0, 1'b0));
        cyc(0, 0);
        check("d2_stall3", obs0, v_shift(3'd1, 1'b0, 1'b0));
        cyc(0, 1);
        check("d2_idx1_go", obs0, v_shift(3'd1, 1'b1, 1'b0));
        cyc(0, 1);
        check("d2_idx2", obs0, v_shift(3'd2, 1'b1, 1'b0));
        cyc(0, 1);
        check("d2_idx3_last", obs0, v_shift(3'd3, 1'b1, 1'b1));
        cyc(0, 1);
        check("d2_done", obs0, V_DONE);
        cyc(0, 1);
        check("d2_idle_after", obs0, V_IDLE);
        check_int("d2_xfers", xfers - xfer_base, 4);

        // Drain 3: start pulsed again at idx 2
        xfer_base = xfers;
        cyc(1, 1);
        cyc(0, 1);
        check("d3_load", obs0, V_LOAD);
        cyc(0, 1);
        cyc(0, 1);
        cyc(1, 1);
        check("d3_idx2_restart", obs0, v_shift(3'd2, 1'b1, 1'b0));
        cyc(0, 1);
        check("d3_idx3_last", obs0, v_shift(3'd3, 1'b1, 1'b1));
        cyc(0, 1);
        check("d3_done", obs0, V_DONE);
`ifdef RESULT_DRAIN_QUEUE_EN
        cyc(0, 1);
        check("d3q_load", obs0, V_LOAD);
        cyc(0, 1);
        check("d3q_idx0", obs0, v_shift(3'd0, 1'b1, 1'b0));
        cyc(0, 1);
        check("d3q_idx1", obs0, v_shift(3'd1, 1'b1, 1'b0));
        cyc(0, 1);
        check("d3q_idx2", obs0, v_shift(3'd2, 1'b1, 1'b0));
        cyc(0, 1);
        check("d3q_idx3_last", obs0, v_shift(3'd3, 1'b1, 1'b1));
        cyc(0, 1);
        check("d3q_done", obs0, V_DONE);
        cyc(0, 1);
        check("d3q_idle_after", obs0, V_IDLE);
        check_int("d3q_xfers", xfers - xfer_base, 8);
`else
        cyc(0, 1);
        check("d3_idle_after", obs0, V_IDLE);
        cyc(0, 1);
        check("d3_still_idle", obs0, V_IDLE);
        check_int("d3_xfers", xfers - xfer_base, 4);
`endif

        // Drain 4: reset at idx 2, then a fresh drain from idx 0
        cyc(1, 1);
        cyc(0, 1);
        cyc(0, 1);
        cyc(0, 1);
        cyc(0, 1);
        check("d4_idx2_pre_rst", obs0, v_shift(3'd2, 1'b1, 1'b0));
        rst = 1'b1;
        cyc(0, 1);
        rst = 1'b0;
        check("d4_after_rst", obs0, V_IDLE);
        cyc(0, 1);
        check("d4_no_done", obs0, V_IDLE);
        xfer_base = xfers;
        cyc(1, 1);
        cyc(0, 1);
        check("d4_load", obs0, V_LOAD);
        cyc(0, 1);
        check("d4_idx0", obs0, v_shift(3'd0, 1'b1, 1'b0));
        cyc(0, 1);
        cyc(0, 1);
        cyc(0, 1);
        check("d4_idx3_last", obs0, v_shift(3'd3, 1'b1, 1'b1));
        cyc(0, 1);
        check("d4_done", obs0, V_DONE);
        cyc(0, 1);
        check("d4_idle_after", obs0, V_IDLE);
        check_int("d4_xfers", xfers - xfer_base, 4);

        // CHAIN_LEN=1 instance
        @(negedge Clk);
        start1 = 1'b1;
        out_ready = 1'b1;
        #1;
        check("c1_T_idle", obs1, V_IDLE);
        @(negedge Clk);
        start1 = 1'b0;
        #1;
        check("c1_load", obs1, V_LOAD);
        @(negedge Clk);
        #1;
        check("c1_idx0_last", obs1, v_shift(3'd0, 1'b1, 1'b1));
        @(negedge Clk);
        #1;
        check("c1_done", obs1, V_DONE);
        @(negedge Clk);
        #1;
        check("c1_idle_after", obs1, V_IDLE);
        check("c1_main_untouched", obs0, V_IDLE);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
